// File: rtl/ysyx_24080006_mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on magnitudes,
// with sign fix on the last step, early-out for divide-by-zero/overflow, and flush abort.
module ysyx_24080006_mdu_iter #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned MUL_STEP = 1,
   parameter int unsigned DIV_STEP = 1
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [1:0]      op_i,
   input  logic            signed_a_i,
   input  logic            signed_b_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o
);

   localparam int unsigned CW = $clog2(XLEN);
   localparam logic [CW-1:0] MulLast = CW'(XLEN / MUL_STEP - 1);
   localparam logic [CW-1:0] DivLast = CW'(XLEN / DIV_STEP - 1);
   localparam logic [1:0] OpMull = 2'd0;
   localparam logic [1:0] OpDiv  = 2'd2;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e              state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic                neg_res_q, neg_res_d;
   logic                neg_rem_q, neg_rem_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   // x: multiplicand (shifting left) or dividend/quotient; y: multiplier or divisor magnitude
   logic [2*XLEN-1:0]   x_q, x_d;
   logic [XLEN:0]       y_q, y_d;
   // acc: running product, or partial remainder in the low XLEN+1 bits
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     res_q, res_d;

   logic                a_neg, b_neg, div_zero, div_ovf, accept, last;
   logic [XLEN:0]       mag_a, mag_b, rem, sh;
   logic [XLEN+1:0]     diff;
   logic [XLEN-1:0]     quo;
   logic [2*XLEN-1:0]   prod, prod_f, xs;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      cnt_d     = cnt_q;
      x_d       = x_q;
      y_d       = y_q;
      acc_d     = acc_q;
      res_d     = res_q;
      a_neg     = signed_a_i & a_i[XLEN-1];
      b_neg     = signed_b_i & b_i[XLEN-1];
      mag_a     = a_neg ? ({1'b0, ~a_i} + (XLEN+1)'(1)) : {1'b0, a_i};
      mag_b     = b_neg ? ({1'b0, ~b_i} + (XLEN+1)'(1)) : {1'b0, b_i};
      div_zero  = (b_i == '0);
      div_ovf   = signed_a_i & signed_b_i & (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (b_i == '1);
      accept    = in_valid_i & (state_q == StIdle) & ~flush_i;
      last      = (cnt_q == (op_q[1] ? DivLast : MulLast));
      prod      = acc_q;
      prod_f    = '0;
      xs        = x_q;
      rem       = acc_q[XLEN:0];
      quo       = x_q[XLEN-1:0];
      sh        = '0;
      diff      = '0;

      case (state_q)
         StIdle: begin
            if (accept) begin
               op_d      = op_i;
               neg_res_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               cnt_d     = '0;
               x_d       = {{(XLEN-1){1'b0}}, mag_a};
               y_d       = mag_b;
               acc_d     = '0;
               if (op_i[1] && div_zero) begin
                  res_d   = (op_i == OpDiv) ? '1 : a_i;
                  state_d = StDone;
               end else if (op_i[1] && div_ovf) begin
                  res_d   = (op_i == OpDiv) ? a_i : '0;
                  state_d = StDone;
               end else begin
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            cnt_d = cnt_q + CW'(1);
            if (!op_q[1]) begin
               for (int unsigned i = 0; i < MUL_STEP; i++) begin
                  if (y_q[i]) prod = prod + xs;
                  xs = xs << 1;
               end
               acc_d = prod;
               x_d   = xs;
               y_d   = y_q >> MUL_STEP;
               if (last) begin
                  prod_f = neg_res_q ? -prod : prod;
                  res_d  = (op_q == OpMull) ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN];
               end
            end else begin
               for (int unsigned i = 0; i < DIV_STEP; i++) begin
                  sh   = {rem[XLEN-1:0], quo[XLEN-1]};
                  quo  = {quo[XLEN-2:0], 1'b0};
                  diff = {1'b0, sh} - {1'b0, y_q};
                  if (!diff[XLEN+1]) begin
                     rem    = diff[XLEN:0];
                     quo[0] = 1'b1;
                  end else begin
                     rem = sh;
                  end
               end
               acc_d = {{(XLEN-1){1'b0}}, rem};
               x_d   = {{XLEN{1'b0}}, quo};
               if (last) begin
                  res_d = (op_q == OpDiv) ? (neg_res_q ? -quo : quo)
                                          : (neg_rem_q ? -rem[XLEN-1:0] : rem[XLEN-1:0]);
               end
            end
            if (last) state_d = StDone;
         end
         StDone: begin
            if (out_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (flush_i) state_d = StIdle;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         op_q      <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         cnt_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         acc_q     <= '0;
         res_q     <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         cnt_q     <= cnt_d;
         x_q       <= x_d;
         y_q       <= y_d;
         acc_q     <= acc_d;
         res_q     <= res_d;
      end
   end

   assign in_ready_o  = (state_q == StIdle);
   assign busy_o      = (state_q != StIdle);
   assign out_valid_o = (state_q == StDone);
   assign result_o    = res_q;

endmodule

// File: tb/tb_ysyx_24080006_mdu_iter.sv
// Directed bench for the iterative MDU: a default-step instance and a MUL_STEP=4/DIV_STEP=2
// instance share stimulus; results and first-valid cycle are checked against hand values.
module tb_ysyx_24080006_mdu_iter;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        flush_i, in_valid_i, out_ready_i, signed_a_i, signed_b_i;
   logic [1:0]  op_i;
   logic [31:0] a_i, b_i;
   logic        in_ready_o, out_valid_o, busy_o;
   logic [31:0] result_o;
   logic        in_ready4, out_valid4, busy4;
   logic [31:0] result4;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [1:0]  op;
      logic        sa;
      logic        sb;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          cyc;
      int          cyc4;
   } vec_t;

   vec_t        vecs [17];
   logic [31:0] r1, r4;
   int          c1, c4;

   always #5 clock = ~clock;

   ysyx_24080006_mdu_iter dut (
      .clock(clock), .reset_n(reset_n), .flush_i(flush_i), .in_valid_i(in_valid_i),
      .in_ready_o(in_ready_o), .op_i(op_i), .signed_a_i(signed_a_i), .signed_b_i(signed_b_i),
      .a_i(a_i), .b_i(b_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .result_o(result_o), .busy_o(busy_o)
   );

   ysyx_24080006_mdu_iter #(.XLEN(32), .MUL_STEP(4), .DIV_STEP(2)) dut4 (
      .clock(clock), .reset_n(reset_n), .flush_i(flush_i), .in_valid_i(in_valid_i),
      .in_ready_o(in_ready4), .op_i(op_i), .signed_a_i(signed_a_i), .signed_b_i(signed_b_i),
      .a_i(a_i), .b_i(b_i), .out_valid_o(out_valid4), .out_ready_i(out_ready_i),
      .result_o(result4), .busy_o(busy4)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%08h required 0x%08h", nm, act, exp);
      end
   endtask

   // Issues one op and records result and first out_valid cycle (accept edge -> cycle 1).
   task automatic run_op(input logic [1:0] op, input logic sa, input logic sb,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res1, output int cy1,
                         output logic [31:0] res4, output int cy4);
      int n;
      res1 = '0; res4 = '0; cy1 = -1; cy4 = -1;
      @(negedge clock);
      op_i = op; signed_a_i = sa; signed_b_i = sb; a_i = a; b_i = b; in_valid_i = 1'b1;
      @(posedge clock); #1;
      in_valid_i = 1'b0;
      n = 1;
      while (n <= 100) begin
         if (out_valid_o && cy1 < 0) begin cy1 = n; res1 = result_o; end
         if (out_valid4 && cy4 < 0) begin cy4 = n; res4 = result4; end
         if (cy1 >= 0 && cy4 >= 0) break;
         @(posedge clock); #1;
         n++;
      end
      @(posedge clock); #1;
   endtask

   initial begin
      int seen;
      reset_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      op_i = 2'd0; signed_a_i = 1'b0; signed_b_i = 1'b0; a_i = '0; b_i = '0;

      vecs[0]  = '{2'd0, 1'b1, 1'b1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 9};
      vecs[1]  = '{2'd1, 1'b1, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 33, 9};
      vecs[2]  = '{2'd1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 9};
      vecs[3]  = '{2'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 9};
      vecs[4]  = '{2'd0, 1'b0, 1'b0, 32'h12345678, 32'h10,       32'h23456780, 33, 9};
      vecs[5]  = '{2'd2, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 17};
      vecs[6]  = '{2'd3, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 17};
      vecs[7]  = '{2'd2, 1'b0, 1'b0, 32'd100,      32'd7,        32'd14,       33, 17};
      vecs[8]  = '{2'd3, 1'b0, 1'b0, 32'd100,      32'd7,        32'd2,        33, 17};
      vecs[9]  = '{2'd2, 1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, 17};
      vecs[10] = '{2'd3, 1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        33, 17};
      vecs[11] = '{2'd2, 1'b0, 1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  1};
      vecs[12] = '{2'd3, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  1};
      vecs[13] = '{2'd2, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1};
      vecs[14] = '{2'd3, 1'b0, 1'b0, 32'd5,        32'd0,        32'd5,        1,  1};
      vecs[15] = '{2'd2, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd3,        32'h55555555, 33, 17};
      vecs[16] = '{2'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        33, 9};

      #2;
      check("reset in_ready", {31'd0, in_ready_o}, 32'd1);
      check("reset out_valid", {31'd0, out_valid_o}, 32'd0);
      check("reset busy", {31'd0, busy_o}, 32'd0);
      check("reset result", result_o, 32'd0);
      @(negedge clock); reset_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         run_op(vecs[i].op, vecs[i].sa, vecs[i].sb, vecs[i].a, vecs[i].b, r1, c1, r4, c4);
         check($sformatf("vec%0d result", i), r1, vecs[i].exp);
         check($sformatf("vec%0d cycle", i), 32'(c1), 32'(vecs[i].cyc));
         check($sformatf("vec%0d result step4", i), r4, vecs[i].exp);
         check($sformatf("vec%0d cycle step4", i), 32'(c4), 32'(vecs[i].cyc4));
      end

      // Backpressure: hold DONE, with a competing request that must be ignored.
      out_ready_i = 1'b0;
      @(negedge clock);
      op_i = 2'd2; signed_a_i = 1'b0; signed_b_i = 1'b0; a_i = 32'd100; b_i = 32'd7;
      in_valid_i = 1'b1;
      @(posedge clock); #1;
      in_valid_i = 1'b0;
      seen = 0;
      for (int n = 0; n < 100 && seen == 0; n++) begin
         @(posedge clock); #1;
         if (out_valid_o) seen = 1;
      end
      check("bp reached done", 32'(seen), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         a_i = 32'd1; b_i = 32'd1; in_valid_i = 1'b1;
         @(posedge clock); #1;
         check($sformatf("bp hold%0d valid", k), {31'd0, out_valid_o}, 32'd1);
         check($sformatf("bp hold%0d result", k), result_o, 32'd14);
         check($sformatf("bp hold%0d in_ready", k), {31'd0, in_ready_o}, 32'd0);
      end
      @(negedge clock); in_valid_i = 1'b0; out_ready_i = 1'b1;
      @(posedge clock); #1;
      check("bp release valid", {31'd0, out_valid_o}, 32'd0);
      check("bp release in_ready", {31'd0, in_ready_o}, 32'd1);

      // Flush in CALC cycle 10, then a flush that must block a same-cycle accept.
      @(negedge clock);
      op_i = 2'd0; signed_a_i = 1'b0; signed_b_i = 1'b0; a_i = 32'd3; b_i = 32'd5;
      in_valid_i = 1'b1;
      @(posedge clock); #1;
      in_valid_i = 1'b0;
      repeat (9) begin @(posedge clock); #1; end
      check("flush pre busy", {31'd0, busy_o}, 32'd1);
      @(negedge clock); flush_i = 1'b1; in_valid_i = 1'b1;
      @(posedge clock); #1;
      check("flush busy", {31'd0, busy_o}, 32'd0);
      check("flush in_ready", {31'd0, in_ready_o}, 32'd1);
      @(posedge clock); #1;
      check("flush blocks accept", {31'd0, busy_o}, 32'd0);
      @(negedge clock); flush_i = 1'b0; in_valid_i = 1'b0;
      seen = 0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clock); #1;
         if (out_valid_o) seen++;
      end
      check("flush no out_valid", 32'(seen), 32'd0);
      run_op(2'd2, 1'b0, 1'b0, 32'd9, 32'd3, r1, c1, r4, c4);
      check("post-flush divu", r1, 32'd3);
      check("post-flush divu cycle", 32'(c1), 32'd33);

      // Asynchronous reset mid-CALC, sampled before any further clock edge.
      @(negedge clock);
      op_i = 2'd0; a_i = 32'd11; b_i = 32'd13; in_valid_i = 1'b1;
      @(posedge clock); #1;
      in_valid_i = 1'b0;
      repeat (5) @(posedge clock);
      @(negedge clock); #1;
      reset_n = 1'b0;
      #1;
      check("async rst busy", {31'd0, busy_o}, 32'd0);
      check("async rst in_ready", {31'd0, in_ready_o}, 32'd1);
      check("async rst valid", {31'd0, out_valid_o}, 32'd0);
      check("async rst result", result_o, 32'd0);
      @(negedge clock); reset_n = 1'b1;
      run_op(2'd0, 1'b0, 1'b0, 32'd6, 32'd7, r1, c1, r4, c4);
      check("post-reset mul", r1, 32'd42);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
